// File: rtl/ad9361_pkg.sv
// Shared types and helpers for the AD9361 TX framer.
// Contents: FSM state type, lane split helpers, channel limit.
package ad9361_pkg;

    localparam int unsigned NUM_CH_MAX   = 2;
    localparam int unsigned SAMPLE_W_MAX = 32;
    localparam int unsigned LANE_W_MAX   = SAMPLE_W_MAX / 2;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    // Upper half of a sample, lane_w bits wide.
    function automatic logic [LANE_W_MAX-1:0] lane_hi(input logic [SAMPLE_W_MAX-1:0] sample,
                                                      input int unsigned lane_w);
        logic [SAMPLE_W_MAX-1:0] mask;
        mask = (SAMPLE_W_MAX'(1) << lane_w) - SAMPLE_W_MAX'(1);
        return LANE_W_MAX'((sample >> lane_w) & mask);
    endfunction

    // Lower half of a sample, lane_w bits wide.
    function automatic logic [LANE_W_MAX-1:0] lane_lo(input logic [SAMPLE_W_MAX-1:0] sample,
                                                      input int unsigned lane_w);
        logic [SAMPLE_W_MAX-1:0] mask;
        mask = (SAMPLE_W_MAX'(1) << lane_w) - SAMPLE_W_MAX'(1);
        return LANE_W_MAX'(sample & mask);
    endfunction

endpackage

// File: rtl/ad9361_tx_framer_if.sv
// Sample-set stream between the DSP side and the framer.
// Signals: s_valid (set valid), s_ready (FIFO not full), s_data (packed I/Q sets, ch0 I in LSBs).
interface ad9361_tx_framer_if #(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned NUM_CH   = 2
);
    localparam int unsigned DATA_W = NUM_CH * 2 * SAMPLE_W;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output and asynchronous reset.
// Ports: clk, rst, wr_en/wr_data (push, ignored when full), rd_en/rd_data (first-word
// fall-through pop, ignored when empty), full, empty, level.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push_c;
    logic             pop_c;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_c  = wr_en && !full;
    assign pop_c   = rd_en && !empty;

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ad9361_tx_framer.sv
// AD9361 TX framer: buffers I/Q sample sets and serialises them into rise/fall
// beat pairs with frame bits for a downstream ODDR stage.
// Ports: sys_clk, rst (async, active high), enable, mode_2ch (latched in IDLE),
// s_if (sample stream), out_data_rise/fall, out_frame_rise/fall, active,
// fifo_level, underflow_cnt.
module ad9361_tx_framer
    import ad9361_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = 12,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PRIME_LEVEL = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mode_2ch,
    ad9361_tx_framer_if.slave             s_if,
    output logic [SAMPLE_W/2-1:0]         out_data_rise,
    output logic [SAMPLE_W/2-1:0]         out_data_fall,
    output logic                          out_frame_rise,
    output logic                          out_frame_fall,
    output logic                          active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              underflow_cnt
);
    localparam int unsigned LANE_W = SAMPLE_W / 2;
    localparam int unsigned DATA_W = NUM_CH * 2 * SAMPLE_W;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  level;

    state_t            state_q;
    logic              mode_q;
    logic [1:0]        beat_q;
    logic [DATA_W-1:0] set_q;
    logic [LANE_W-1:0] rise_q;
    logic [LANE_W-1:0] fall_q;
    logic              frame_q;
    logic [CNT_W-1:0]  uf_q;

    logic              slot_start_c;
    logic              pop_c;
    logic [1:0]        last_beat_c;
    logic [1:0]        beat_d;
    logic [DATA_W-1:0] set_d;
    logic [DATA_W-1:0] chan_c;
    logic [SAMPLE_W-1:0] samp_i_c;
    logic [SAMPLE_W-1:0] samp_q_c;
    logic [LANE_W-1:0] rise_d;
    logic [LANE_W-1:0] fall_d;
    logic              frame_d;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .wr_en   (s_if.s_valid),
        .wr_data (s_if.s_data),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign s_if.s_ready   = !fifo_full;
    assign fifo_level     = level;
    assign out_data_rise  = rise_q;
    assign out_data_fall  = fall_q;
    assign out_frame_rise = frame_q;
    assign out_frame_fall = frame_q;
    assign active         = (state_q == RUN);
    assign underflow_cnt  = uf_q;

    // A slot starts whenever the beat counter is back at zero; a stop request
    // is honoured only there, so the slot already on the wire always finishes.
    assign slot_start_c = (state_q == RUN) && (beat_q == 2'd0);
    assign pop_c        = slot_start_c && enable && !fifo_empty;
    assign last_beat_c  = mode_q ? 2'd3 : 2'd1;

    // Next beat: beat 0 comes straight from the FIFO head (zero on underflow).
    always_comb begin
        set_d    = set_q;
        if (slot_start_c) set_d = fifo_empty ? '0 : fifo_rd_data;
        beat_d   = (beat_q == last_beat_c) ? 2'd0 : beat_q + 2'd1;
        chan_c   = (mode_q && beat_q[1]) ? (set_d >> (2 * SAMPLE_W)) : set_d;
        samp_i_c = chan_c[SAMPLE_W-1:0];
        samp_q_c = chan_c[2*SAMPLE_W-1:SAMPLE_W];
        if (!beat_q[0]) begin
            rise_d = LANE_W'(lane_hi(SAMPLE_W_MAX'(samp_i_c), LANE_W));
            fall_d = LANE_W'(lane_hi(SAMPLE_W_MAX'(samp_q_c), LANE_W));
        end else begin
            rise_d = LANE_W'(lane_lo(SAMPLE_W_MAX'(samp_i_c), LANE_W));
            fall_d = LANE_W'(lane_lo(SAMPLE_W_MAX'(samp_q_c), LANE_W));
        end
        frame_d  = mode_q ? !beat_q[1] : !beat_q[0];
    end

    // Control FSM with registered beat outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            beat_q  <= 2'd0;
            set_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            frame_q <= 1'b0;
            uf_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mode_q  <= mode_2ch && (NUM_CH == NUM_CH_MAX);
                    rise_q  <= '0;
                    fall_q  <= '0;
                    frame_q <= 1'b0;
                    if (enable) state_q <= PRIME;
                end
                PRIME: begin
                    rise_q  <= '0;
                    fall_q  <= '0;
                    frame_q <= 1'b0;
                    beat_q  <= 2'd0;
                    if (!enable)                             state_q <= IDLE;
                    else if (level >= LVL_W'(PRIME_LEVEL))   state_q <= RUN;
                end
                RUN: begin
                    if (slot_start_c && !enable) begin
                        state_q <= IDLE;
                        rise_q  <= '0;
                        fall_q  <= '0;
                        frame_q <= 1'b0;
                    end else begin
                        set_q   <= set_d;
                        beat_q  <= beat_d;
                        rise_q  <= rise_d;
                        fall_q  <= fall_d;
                        frame_q <= frame_d;
                        if (slot_start_c && fifo_empty && (uf_q != '1))
                            uf_q <= uf_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9361_tx_framer.sv
// Self-checking bench for ad9361_tx_framer (SAMPLE_W=12, NUM_CH=2, depth 16, CNT_W=4).
module tb_ad9361_tx_framer;

    localparam int unsigned SW    = 12;
    localparam int unsigned NC    = 2;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PL    = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned LW    = SW / 2;
    localparam int unsigned DW    = NC * 2 * SW;

    typedef struct packed {
        logic [LW-1:0] rise;
        logic [LW-1:0] fall;
        logic          frame;
    } beat_t;

    typedef struct packed {
        logic          mode;
        logic [11:0]   i0;
        logic [11:0]   q0;
        logic [11:0]   i1;
        logic [11:0]   q1;
        logic [2:0]    nb;
        logic [3:0][5:0] rise;
        logic [3:0][5:0] fall;
        logic [3:0]    frame;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic                 mode_2ch;
    logic [LW-1:0]        out_data_rise;
    logic [LW-1:0]        out_data_fall;
    logic                 out_frame_rise;
    logic                 out_frame_fall;
    logic                 active;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CW-1:0]        underflow_cnt;

    ad9361_tx_framer_if #(.SAMPLE_W(SW), .NUM_CH(NC)) s_if ();

    ad9361_tx_framer #(
        .SAMPLE_W    (SW),
        .NUM_CH      (NC),
        .FIFO_DEPTH  (DEPTH),
        .PRIME_LEVEL (PL),
        .CNT_W       (CW)
    ) dut (
        .sys_clk        (clk),
        .rst            (rst),
        .enable         (enable),
        .mode_2ch       (mode_2ch),
        .s_if           (s_if),
        .out_data_rise  (out_data_rise),
        .out_data_fall  (out_data_fall),
        .out_frame_rise (out_frame_rise),
        .out_frame_fall (out_frame_fall),
        .active         (active),
        .fifo_level     (fifo_level),
        .underflow_cnt  (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = waiting, 1 = priming, 2 = transmitting.
    int            m_phase;
    bit            m_mode;
    int            m_uf;
    beat_t         m_out;
    logic [DW-1:0] m_fifo[$];
    beat_t         m_beats[$];

    task automatic model_reset();
        m_phase = 0;
        m_mode  = 1'b0;
        m_uf    = 0;
        m_out   = '0;
        m_fifo.delete();
        m_beats.delete();
    endtask

    // Expand one sample set into the beats it produces on the wire.
    task automatic build_slot(input logic [DW-1:0] st);
        int nch;
        nch = m_mode ? 2 : 1;
        for (int c = 0; c < nch; c++) begin
            int unsigned si;
            int unsigned sq;
            beat_t b;
            si = 32'((st >> (c * 24)) & 48'hFFF);
            sq = 32'((st >> (c * 24 + 12)) & 48'hFFF);
            b.rise  = 6'(si / 64);
            b.fall  = 6'(sq / 64);
            b.frame = m_mode ? (c == 0) : 1'b1;
            m_beats.push_back(b);
            b.rise  = 6'(si % 64);
            b.fall  = 6'(sq % 64);
            b.frame = m_mode ? (c == 0) : 1'b0;
            m_beats.push_back(b);
        end
    endtask

    task automatic model_step();
        bit ready;
        logic [DW-1:0] st;
        ready = (m_fifo.size() < DEPTH);
        case (m_phase)
            0: begin
                m_mode = mode_2ch;
                m_out  = '0;
                if (enable) m_phase = 1;
            end
            1: begin
                m_out = '0;
                if (!enable) m_phase = 0;
                else if (m_fifo.size() >= PL) begin
                    m_phase = 2;
                    m_beats.delete();
                end
            end
            default: begin
                if (m_beats.size() == 0) begin
                    if (!enable) begin
                        m_phase = 0;
                        m_out   = '0;
                    end else begin
                        if (m_fifo.size() > 0) st = m_fifo.pop_front();
                        else begin
                            st = '0;
                            if (m_uf < (1 << CW) - 1) m_uf++;
                        end
                        build_slot(st);
                    end
                end
                if (m_phase == 2) m_out = m_beats.pop_front();
            end
        endcase
        if (s_if.s_valid && ready) m_fifo.push_back(s_if.s_data);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string name);
        bit ok;
        logic [$clog2(DEPTH):0] exp_lvl;
        exp_lvl = ($clog2(DEPTH)+1)'(m_fifo.size());
        ok = (out_data_rise === m_out.rise) && (out_data_fall === m_out.fall) &&
             (out_frame_rise === m_out.frame) && (out_frame_fall === m_out.frame) &&
             (active === (m_phase == 2)) && (s_if.s_ready === (m_fifo.size() < DEPTH)) &&
             (fifo_level === exp_lvl) && (underflow_cnt === CW'(m_uf));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got rise=%h fall=%h fr=%b/%b act=%b rdy=%b lvl=%0d uf=%0d; expected rise=%h fall=%h fr=%b act=%b rdy=%b lvl=%0d uf=%0d at %0t",
                     name, out_data_rise, out_data_fall, out_frame_rise, out_frame_fall, active,
                     s_if.s_ready, fifo_level, underflow_cnt, m_out.rise, m_out.fall, m_out.frame,
                     (m_phase == 2), (m_fifo.size() < DEPTH), m_fifo.size(), m_uf, $time);
        end
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_all("cycle");
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        mode_2ch    = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_active();
        for (int i = 0; i < 10; i++) begin
            if (active) break;
            tick();
        end
        chk("wait_active", 32'(active), 32'd1);
    endtask

    task automatic push_sets(input logic [DW-1:0] d, input int n);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        repeat (n) tick();
        s_if.s_valid = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        mode_2ch = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data = '0;

        vecs[0] = '{mode:1'b0, i0:12'hABC, q0:12'h555, i1:12'h000, q1:12'h000, nb:3'd2,
                    rise:{6'h00, 6'h00, 6'h3C, 6'h2A}, fall:{6'h00, 6'h00, 6'h15, 6'h15},
                    frame:4'b0001};
        vecs[1] = '{mode:1'b1, i0:12'hFC0, q0:12'h03F, i1:12'h123, q1:12'h456, nb:3'd4,
                    rise:{6'h23, 6'h04, 6'h00, 6'h3F}, fall:{6'h16, 6'h11, 6'h3F, 6'h00},
                    frame:4'b0011};
        vecs[2] = '{mode:1'b1, i0:12'hFFF, q0:12'h000, i1:12'h000, q1:12'hFFF, nb:3'd4,
                    rise:{6'h00, 6'h00, 6'h3F, 6'h3F}, fall:{6'h3F, 6'h3F, 6'h00, 6'h00},
                    frame:4'b0011};
        vecs[3] = '{mode:1'b0, i0:12'h041, q0:12'hFC2, i1:12'h777, q1:12'h777, nb:3'd2,
                    rise:{6'h00, 6'h00, 6'h01, 6'h01}, fall:{6'h00, 6'h00, 6'h02, 6'h3F},
                    frame:4'b0001};

        // Reset defaults.
        do_reset();
        chk("rst_rise", 32'(out_data_rise), 32'd0);
        chk("rst_ready", 32'(s_if.s_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_active", 32'(active), 32'd0);

        // Table-driven framing vectors, two slots each.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            mode_2ch = vecs[v].mode;
            push_sets({vecs[v].q1, vecs[v].i1, vecs[v].q0, vecs[v].i0}, 4);
            enable = 1'b1;
            wait_active();
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < int'(vecs[v].nb); k++) begin
                    tick();
                    chk("vec_rise", 32'(out_data_rise), 32'(vecs[v].rise[k]));
                    chk("vec_fall", 32'(out_data_fall), 32'(vecs[v].fall[k]));
                    chk("vec_frame", 32'(out_frame_rise), 32'(vecs[v].frame[k]));
                end
            end
            enable = 1'b0;
            repeat (6) tick();
        end

        // Underflow fill and counter saturation in 1T.
        do_reset();
        push_sets({12'h0, 12'h0, 12'h555, 12'hABC}, 4);
        enable = 1'b1;
        wait_active();
        repeat (8) tick();
        tick();
        chk("uf_first_rise", 32'(out_data_rise), 32'd0);
        chk("uf_first_frame", 32'(out_frame_rise), 32'd1);
        chk("uf_first_cnt", 32'(underflow_cnt), 32'd1);
        repeat (40) tick();
        chk("uf_sat", 32'(underflow_cnt), 32'hF);
        chk("uf_still_active", 32'(active), 32'd1);

        // Back-pressure: fill in IDLE, then stream 2T with s_valid held high.
        do_reset();
        s_if.s_valid = 1'b1;
        s_if.s_data  = 48'h123456789ABC;
        repeat (20) tick();
        chk("bp_level", 32'(fifo_level), 32'd16);
        chk("bp_ready", 32'(s_if.s_ready), 32'd0);
        mode_2ch = 1'b1;
        enable   = 1'b1;
        wait_active();
        begin
            int low_cnt;
            low_cnt = 0;
            for (int i = 0; i < 40; i++) begin
                s_if.s_data = DW'({$urandom(), $urandom()});
                tick();
                if (fifo_level < 15) low_cnt++;
            end
            chk("bp_level_held", 32'(low_cnt), 32'd0);
        end
        // Asynchronous reset in the middle of a slot.
        #2 rst = 1'b1;
        #1;
        chk("arst_rise", 32'(out_data_rise), 32'd0);
        chk("arst_frame", 32'(out_frame_rise), 32'd0);
        chk("arst_ready", 32'(s_if.s_ready), 32'd1);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_active", 32'(active), 32'd0);
        model_reset();
        enable = 1'b0;
        s_if.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Stop requested on 2T beat 2: beats 3 and 4 still go out.
        do_reset();
        mode_2ch = 1'b1;
        push_sets({12'h456, 12'h123, 12'h03F, 12'hFC0}, 4);
        enable = 1'b1;
        wait_active();
        tick();
        tick();
        chk("stop_b2_rise", 32'(out_data_rise), 32'h00);
        enable = 1'b0;
        tick();
        chk("stop_b3_rise", 32'(out_data_rise), 32'h04);
        chk("stop_b3_frame", 32'(out_frame_fall), 32'd0);
        tick();
        chk("stop_b4_fall", 32'(out_data_fall), 32'h16);
        tick();
        chk("stop_idle_rise", 32'(out_data_rise), 32'd0);
        chk("stop_idle_frame", 32'(out_frame_rise), 32'd0);
        chk("stop_idle_active", 32'(active), 32'd0);
        chk("stop_retained", 32'(fifo_level), 32'd3);

        // Randomised traffic against the model.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            mode_2ch     = 1'($urandom_range(0, 1));
            s_if.s_valid = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                : ($urandom_range(0, 3) == 0);
            s_if.s_data  = DW'({$urandom(), $urandom()});
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
